// File: rtl/sc_add_sequencer.sv
// Sequencer for one stochastic scaled add on an external mux adder (out = sel ? y : x).
// Optional abort of a running stream is enabled by defining SC_ADD_ABORT_EN.
module sc_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_val,
  input  logic [WIDTH-1:0] y_val,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             sc_x,
  output logic             sc_y,
  output logic             sc_sel,
  input  logic             sc_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH:0]   r_cnt, r_acc, r_result, w_sum;
  logic [WIDTH-1:0] r_xr, r_yr, w_rev;
  logic             w_run, w_last, w_abort;

`ifdef SC_ADD_ABORT_EN
  assign w_abort = abort;
`else
  logic w_unused_abort;
  assign w_unused_abort = abort;
  assign w_abort        = 1'b0;
`endif

  assign w_run  = (r_state == RUN);
  assign w_last = &r_cnt;
  assign w_sum  = r_acc + {{WIDTH{1'b0}}, sc_out};

  // r = bit-reverse of k = cnt[WIDTH:1]; so r[i] = cnt[WIDTH-i]
  always_comb begin
    w_rev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_rev[i] = r_cnt[WIDTH-i];
    end
  end

  assign sc_sel = w_run & r_cnt[0];
  assign sc_x   = w_run & (r_xr > w_rev);
  assign sc_y   = w_run & (r_yr > w_rev);

  assign ready  = (r_state == IDLE);
  assign busy   = w_run;
  assign done   = (r_state == DONE);
  assign result = r_result;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN: begin
        if (w_abort)     w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_xr     <= '0;
      r_yr     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_xr  <= x_val;
            r_yr  <= y_val;
            r_cnt <= '0;
            r_acc <= '0;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_cnt <= '0;
            r_acc <= '0;
          end else begin
            r_cnt <= r_cnt + (WIDTH+1)'(1);
            r_acc <= w_sum;
            if (w_last) r_result <= w_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sc_add_sequencer.md
Name: sc_add_sequencer

Overview:
- Sequences one stochastic scaled-add operation on an external mux-based sc_adder, where out = sel ? y : x.
- Accepts two WIDTH-bit binary operands and generates their unipolar bitstreams with a bit-reversed-counter SNG.
- Drives x, y and sel to the adder, counts the ones on its output over a full stream, and returns the binary count through a start/done handshake.
- Sits between binary control logic and the SC datapath.

Parameters:
- WIDTH, 8, operand precision in bits; stream length is 2^(WIDTH+1) cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- x_val  in  WIDTH  operand X, sampled on accept
- y_val  in  WIDTH  operand Y, sampled on accept
- abort  in  1  cancel request; functional only with SC_ADD_ABORT_EN
- ready  out  1  high in IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- result  out  WIDTH+1  ones count of the last completed stream
- sc_x  out  1  to adder x
- sc_y  out  1  to adder y
- sc_sel  out  1  to adder sel
- sc_out  in  1  from adder out (combinational return)

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; cnt=0; acc=0; result=0; done=0.
  - Latched operands xr=yr=0.
  - rst overrides all other inputs, including mid-RUN: the stream is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch xr<=x_val and yr<=y_val; set cnt<=0, acc<=0; go to RUN.
  - start=0: remain in IDLE.
- RUN (busy=1, ready=0), lasts exactly 2^(WIDTH+1) cycles:
  - cnt is a (WIDTH+1)-bit counter; k=cnt[WIDTH:1]; r=bit-reverse of k (WIDTH bits).
  - sc_sel=cnt[0].
  - sc_x=(xr > r), unsigned compare.
  - sc_y=(yr > r), unsigned compare.
  - All sc_* are combinational from registers, and forced to 0 outside RUN.
  - Each RUN cycle: acc<=acc+sc_out (acc is WIDTH+1 bits and never overflows); cnt<=cnt+1.
  - On the cycle with cnt=all-ones: result<=acc+sc_out; go to DONE. cnt wraps to 0.
- DONE:
  - done=1 for exactly one cycle; ready=0.
  - Next edge: IDLE unconditionally.
- start is ignored whenever state != IDLE, including in the DONE cycle. It is not queued.
- Exactness:
  - Each k is visited once with sel=0 and once with sel=1. r is a permutation of 0..2^WIDTH-1.
  - Therefore result = xr + yr exactly. The scaled SC value is result/2^(WIDTH+1) = (X+Y)/2.
- Latency:
  - start is accepted at edge E.
  - done is high in the cycle following edge E+2^(WIDTH+1).
  - result is valid from that same cycle and held until the next completion or reset.
- x_val and y_val are don't-care outside the accept cycle. Changes during RUN have no effect.

Optional Feature:
- Macro SC_ADD_ABORT_EN.
- Defined:
  - abort=1 in RUN → next edge goes to IDLE; cnt=0; acc=0; result unchanged; no done pulse.
  - abort in IDLE or DONE is ignored.
  - If abort and the last RUN cycle coincide, abort wins: no done and no result update.
- Undefined:
  - The abort port exists but is ignored.
  - All runs complete normally.

Test Plan (WIDTH=8):
- Reset, then start with x_val=0, y_val=0 → sc_x and sc_y stay 0 for all 512 RUN cycles; done 513 cycles after the accept edge; result=0.
- x_val=255, y_val=255 → result=510; exactly 255 ones on sc_x while sc_sel=0.
- x_val=100, y_val=37 → result=137, and the ones count of sc_out equals 137. A second run with x_val=1, y_val=0 → result=1.
- Pulse start and change x_val at RUN cycle 10, and again in the DONE cycle → both ignored; the result from the first accept is correct; ready rises the cycle after done.
- Assert rst at RUN cycle 200 → next cycle ready=1, result=0, done never pulses; a new run with 3,4 → result=7.
- With SC_ADD_ABORT_EN: run 50,50 to completion (result=100), then start 10,20 and abort at cycle 300 → IDLE, no done, result stays 100.
- Without SC_ADD_ABORT_EN: the same abort stimulus → result=30 with done.
